// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per clock.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          request, sampled only while idle
//   kill           synchronous abort, wins over start
//   op[2:0]        funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   a, b [N-1:0]   rs1 / rs2 operands
//   busy           operation in flight (CALC or FIN)
//   done           one-cycle pulse, result valid
//   result[N-1:0]  last completed value, held until next completion
//
// Flow: IDLE -> CALC (N steps) -> FIN -> IDLE. Latency is N+1 edges from
// accept to done for every op, including divide-by-zero and overflow.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         kill,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t state, nxt;

    logic [2:0]    op_q;
    logic [N-1:0]  m;        // multiplicand (mul) or divisor (div) magnitude
    logic [N-1:0]  hi;       // product high half / partial remainder
    logic [N-1:0]  lo;       // multiplier -> product low / dividend -> quotient
    logic [CW-1:0] cnt;
    logic          neg_q;    // product / quotient sign
    logic          sa_q;     // remainder sign
    logic          spec_q;
    logic [N-1:0]  sval_q;

    // ---- capture-time decode ----
    logic         is_div, a_sgn, b_sgn, sa, sb, dz, ovf;
    logic [N-1:0] abs_a, abs_b, sval;

    always_comb begin
        is_div = op[2];
        a_sgn  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa     = a_sgn & a[N-1];
        sb     = b_sgn & b[N-1];
        abs_a  = sa ? -a : a;
        abs_b  = sb ? -b : b;
        dz     = is_div && (b == '0);
        ovf    = ((op == 3'b100) || (op == 3'b110)) &&
                 (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
        sval   = '0;
        if (dz)       sval = op[1] ? a : '1;
        else if (ovf) sval = op[1] ? '0 : a;
    end

    // ---- one iteration step ----
    logic [N:0] mul_sum, div_sh, div_tr;
    logic       q_bit;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_sh  = {hi, lo[N-1]};
        div_tr  = div_sh - {1'b0, m};
        // hi < m keeps div_sh below 2m, so bit N of the difference is a clean borrow flag
        q_bit   = ~div_tr[N];
    end

    // ---- sign fix-up and output selection ----
    logic [2*N-1:0] prod, sprod;
    logic [N-1:0]   quo, rem, fin_val;

    always_comb begin
        prod  = {hi, lo};
        sprod = neg_q ? -prod : prod;
        quo   = neg_q ? -lo : lo;
        rem   = sa_q ? -hi : hi;
        if (spec_q)           fin_val = sval_q;
        else if (!op_q[2])    fin_val = (op_q[1:0] == 2'b00) ? sprod[N-1:0] : sprod[2*N-1:N];
        else                  fin_val = op_q[1] ? rem : quo;
    end

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = CALC;
            CALC: if (cnt == CW'(N-1)) nxt = FIN;
            FIN:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end

    assign busy = (state != IDLE);

    // ---- datapath ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
            spec_q <= 1'b0;
            sval_q <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !kill) begin
                    op_q   <= op;
                    m      <= is_div ? abs_b : abs_a;
                    lo     <= is_div ? abs_a : abs_b;
                    hi     <= '0;
                    cnt    <= '0;
                    neg_q  <= sa ^ sb;
                    sa_q   <= sa;
                    spec_q <= dz | ovf;
                    sval_q <= sval;
                end
                CALC: if (!kill) begin
                    cnt <= cnt + CW'(1);
                    if (!op_q[2]) begin
                        hi <= mul_sum[N:1];
                        lo <= {mul_sum[0], lo[N-1:1]};
                    end else begin
                        hi <= q_bit ? div_tr[N-1:0] : div_sh[N-1:0];
                        lo <= {lo[N-2:0], q_bit};
                    end
                end
                FIN: if (!kill) begin
                    result <= fin_val;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
